// File: rtl/ysyx_22051013_pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush scheduler.
// Optional performance counters are enabled with YSYX_22051013_PIPE_PERF_EN.
package ysyx_22051013_pipe_ctrl_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int MEM_TMO_DEF = 255;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ERR  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exls_stall;
        logic ifid_flush;
        logic idex_flush;
        logic exls_flush;
        logic lswb_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/ysyx_22051013_pipe_ctrl_if.sv
// Hazard inputs and stall/flush outputs between the pipeline stages and the scheduler.
// The master side is the datapath; the slave side is the scheduler.
interface ysyx_22051013_pipe_ctrl_if
    import ysyx_22051013_pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs1_ren;
    logic              id_rs2_ren;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_rd_ena;
    logic              ex_is_load;
    logic              ex_mc_busy;
    logic              ex_redirect;
    logic              ls_mem_req;
    logic              ls_mem_ack;
    logic              if_fetch_busy;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_stall;
    logic              exls_stall;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exls_flush;
    logic              lswb_flush;
    logic              redirect_pend;
    logic              mem_tmo_err;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
        output ex_rd_addr, ex_rd_ena, ex_is_load, ex_mc_busy, ex_redirect,
        output ls_mem_req, ls_mem_ack, if_fetch_busy,
        input  pc_stall, ifid_stall, idex_stall, exls_stall,
        input  ifid_flush, idex_flush, exls_flush, lswb_flush,
        input  redirect_pend, mem_tmo_err
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
        input  ex_rd_addr, ex_rd_ena, ex_is_load, ex_mc_busy, ex_redirect,
        input  ls_mem_req, ls_mem_ack, if_fetch_busy,
        output pc_stall, ifid_stall, idex_stall, exls_stall,
        output ifid_flush, idex_flush, exls_flush, lswb_flush,
        output redirect_pend, mem_tmo_err
    );

endinterface

// File: rtl/ysyx_22051013_hazard_det.sv
// Load-use hazard detector: flags an ID source register that a load in EX will write.
// Purely combinational so a later forwarding unit can share it.
module ysyx_22051013_hazard_det
    import ysyx_22051013_pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_ren,
    input  logic              id_rs2_ren,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_rd_ena,
    input  logic              ex_is_load,
    output logic              lu_hit
);

    logic rs1_hit_s;
    logic rs2_hit_s;
    logic rd_live_s;

    // x0 is never a real destination, so a load to it cannot create a hazard
    always_comb begin
        rs1_hit_s = id_rs1_ren & (id_rs1_addr == ex_rd_addr);
        rs2_hit_s = id_rs2_ren & (id_rs2_addr == ex_rd_addr);
        rd_live_s = ex_is_load & ex_rd_ena & (ex_rd_addr != {REG_AW{1'b0}});
        lu_hit    = rd_live_s & (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline, with memory-wait FSM and redirect latch.
// Define YSYX_22051013_PIPE_PERF_EN to add the perf_* event counters.
module ysyx_22051013_pipe_ctrl
    import ysyx_22051013_pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MEM_TMO = MEM_TMO_DEF,
    parameter int TMO_W   = 8
`ifdef YSYX_22051013_PIPE_PERF_EN
    ,
    parameter int PERF_W  = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22051013_pipe_ctrl_if.slave bus
`ifdef YSYX_22051013_PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0]       perf_mem_stall,
    output logic [PERF_W-1:0]       perf_lu_bubble,
    output logic [PERF_W-1:0]       perf_redirect
`endif
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    mem_state_e       state_q;
    mem_state_e       state_d;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             redirect_pend_q;
    logic             redirect_pend_d;

    logic             lu_hit_s;
    logic             mem_stall_s;
    logic             redir_now_s;
    logic             mem_case_s;
    logic             redir_case_s;
    logic             lu_case_s;
    pipe_ctrl_t       ctrl_s;

    ysyx_22051013_hazard_det #(
        .REG_AW (REG_AW)
    ) u_hazard_det (
        .id_rs1_addr (bus.id_rs1_addr),
        .id_rs2_addr (bus.id_rs2_addr),
        .id_rs1_ren  (bus.id_rs1_ren),
        .id_rs2_ren  (bus.id_rs2_ren),
        .ex_rd_addr  (bus.ex_rd_addr),
        .ex_rd_ena   (bus.ex_rd_ena),
        .ex_is_load  (bus.ex_is_load),
        .lu_hit      (lu_hit_s)
    );

    // FSM state, timeout counter and redirect latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= M_IDLE;
            cnt_q           <= {TMO_W{1'b0}};
            redirect_pend_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            redirect_pend_q <= redirect_pend_d;
        end
    end

    // Memory-wait FSM next state; ack takes precedence over the timeout check
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            M_IDLE: begin
                if (bus.ls_mem_req & ~bus.ls_mem_ack) begin
                    state_d = M_WAIT;
                    cnt_d   = {TMO_W{1'b0}};
                end else begin
                    state_d = M_IDLE;
                end
            end
            M_WAIT: begin
                if (bus.ls_mem_ack) begin
                    state_d = M_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = M_ERR;
                end else begin
                    cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            M_ERR: begin
                state_d = M_ERR;
            end
            default: begin
                state_d = M_IDLE;
                cnt_d   = {TMO_W{1'b0}};
            end
        endcase
    end

    // Priority resolution of stall/flush controls, first match wins
    always_comb begin
        mem_stall_s  = (bus.ls_mem_req & ~bus.ls_mem_ack) | (state_q == M_ERR);
        redir_now_s  = bus.ex_redirect | redirect_pend_q;
        ctrl_s       = '0;
        mem_case_s   = 1'b0;
        redir_case_s = 1'b0;
        lu_case_s    = 1'b0;
        if (rst) begin
            ctrl_s = '0;
        end else if (mem_stall_s) begin
            mem_case_s        = 1'b1;
            ctrl_s.pc_stall   = 1'b1;
            ctrl_s.ifid_stall = 1'b1;
            ctrl_s.idex_stall = 1'b1;
            ctrl_s.exls_stall = 1'b1;
            ctrl_s.lswb_flush = 1'b1;
        end else if (bus.ex_mc_busy) begin
            ctrl_s.pc_stall   = 1'b1;
            ctrl_s.ifid_stall = 1'b1;
            ctrl_s.idex_stall = 1'b1;
            ctrl_s.exls_flush = 1'b1;
        end else if (redir_now_s) begin
            // wrong-path instructions in IF/ID and ID/EX are dropped, so nothing is held
            redir_case_s      = 1'b1;
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
        end else if (lu_hit_s) begin
            lu_case_s         = 1'b1;
            ctrl_s.pc_stall   = 1'b1;
            ctrl_s.ifid_stall = 1'b1;
            ctrl_s.idex_flush = 1'b1;
        end else if (bus.if_fetch_busy) begin
            ctrl_s.pc_stall   = 1'b1;
            ctrl_s.ifid_flush = 1'b1;
        end else begin
            ctrl_s = '0;
        end
    end

    // Redirects arriving while the pipe is held are remembered until they can be applied
    always_comb begin
        if (mem_stall_s | bus.ex_mc_busy) begin
            redirect_pend_d = redirect_pend_q | bus.ex_redirect;
        end else if (redir_now_s) begin
            redirect_pend_d = 1'b0;
        end else begin
            redirect_pend_d = redirect_pend_q;
        end
    end

    assign bus.pc_stall      = ctrl_s.pc_stall;
    assign bus.ifid_stall    = ctrl_s.ifid_stall;
    assign bus.idex_stall    = ctrl_s.idex_stall;
    assign bus.exls_stall    = ctrl_s.exls_stall;
    assign bus.ifid_flush    = ctrl_s.ifid_flush;
    assign bus.idex_flush    = ctrl_s.idex_flush;
    assign bus.exls_flush    = ctrl_s.exls_flush;
    assign bus.lswb_flush    = ctrl_s.lswb_flush;
    assign bus.redirect_pend = redirect_pend_q & ~rst;
    assign bus.mem_tmo_err   = (state_q == M_ERR) & ~rst;

`ifdef YSYX_22051013_PIPE_PERF_EN
    logic [PERF_W-1:0] perf_mem_q;
    logic [PERF_W-1:0] perf_mem_d;
    logic [PERF_W-1:0] perf_lu_q;
    logic [PERF_W-1:0] perf_lu_d;
    logic [PERF_W-1:0] perf_redir_q;
    logic [PERF_W-1:0] perf_redir_d;

    // Event counters wrap naturally on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_q   <= {PERF_W{1'b0}};
            perf_lu_q    <= {PERF_W{1'b0}};
            perf_redir_q <= {PERF_W{1'b0}};
        end else begin
            perf_mem_q   <= perf_mem_d;
            perf_lu_q    <= perf_lu_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    // Counter increments
    always_comb begin
        perf_mem_d   = perf_mem_q   + {{(PERF_W-1){1'b0}}, mem_case_s};
        perf_lu_d    = perf_lu_q    + {{(PERF_W-1){1'b0}}, lu_case_s};
        perf_redir_d = perf_redir_q + {{(PERF_W-1){1'b0}}, redir_case_s};
    end

    assign perf_mem_stall = perf_mem_q;
    assign perf_lu_bubble = perf_lu_q;
    assign perf_redirect  = perf_redir_q;
`endif

endmodule

// File: doc/ysyx_22051013_pipe_ctrl.md
Name: ysyx_22051013_pipe_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline (IF/ID, ID/EX, EX/LS, LS/WB registers plus PC).
- Detects load-use hazards, multi-cycle EX occupancy, data-memory wait and branch redirects.
- Drives one active-high stall and one active-high flush per pipeline register.
- Contains a memory-wait FSM with timeout and a pending-redirect latch.

Parameters:
REG_AW, 5, register address width
MEM_TMO, 255, max cycles in WAIT before timeout error
TMO_W, 8, timeout counter width (must satisfy 2^TMO_W > MEM_TMO)
PERF_W, 32, perf counter width (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_rs1_addr / id_rs2_addr  in  REG_AW  ID source registers
id_rs1_ren / id_rs2_ren  in  1  ID source read enables
ex_rd_addr  in  REG_AW  EX destination register
ex_rd_ena  in  1  EX writes rd
ex_is_load  in  1  EX holds a load
ex_mc_busy  in  1  multi-cycle mul/div occupying EX
ex_redirect  in  1  one-cycle pulse: taken branch/jump resolved in EX
ls_mem_req  in  1  LS holds a valid memory op
ls_mem_ack  in  1  data memory completes this cycle
if_fetch_busy  in  1  instruction fetch not yet returned
pc_stall, ifid_stall, idex_stall, exls_stall  out  1  hold register
ifid_flush, idex_flush, exls_flush, lswb_flush  out  1  load bubble
redirect_pend  out  1  redirect latched, not yet applied
mem_tmo_err  out  1  sticky timeout error

Behaviour:
Reset:
- All outputs 0; FSM = M_IDLE; timeout counter = 0; redirect_pend = 0.

Memory FSM:
- M_IDLE: if ls_mem_req & !ls_mem_ack, go to M_WAIT and clear the counter. A request with ack in the same cycle stays in M_IDLE with no stall.
- M_WAIT: ack returns to M_IDLE. Otherwise the counter increments; when counter == MEM_TMO-1 and there is no ack, go to M_ERR.
- M_ERR: terminal until rst. mem_tmo_err = 1.

Stall conditions:
- mem_stall = (ls_mem_req & !ls_mem_ack) | state == M_ERR. Combinational, so it is asserted in the first request cycle.
- lu_hit = ex_is_load & ex_rd_ena & ex_rd_addr != 0 & ((id_rs1_ren & rs1 == rd) | (id_rs2_ren & rs2 == rd)).

Priority, first match wins:
1. mem_stall: pc/ifid/idex/exls stall = 1, lswb_flush = 1.
2. ex_mc_busy: pc/ifid/idex stall = 1, exls_flush = 1.
3. redir_now = ex_redirect | redirect_pend: ifid_flush = idex_flush = 1, all stalls = 0. Overrides load-use and fetch stalls.
4. lu_hit: pc/ifid stall = 1, idex_flush = 1. Exactly one bubble, because the load then moves to LS.
5. if_fetch_busy: pc_stall = 1, ifid_flush = 1.
6. Otherwise all 0.

Redirect latch:
- redirect_pend is set on ex_redirect while case 1 or 2 holds.
- It is cleared in the cycle case 3 applies.
- A new ex_redirect while already pending keeps it set.
- The same-cycle redirect without a stall is applied directly and not latched.

Invariant: never stall and flush the same register in one cycle.

Reset mid-operation: rst overrides everything next edge. A pending redirect is dropped and the FSM returns to M_IDLE.

Optional Feature:
YSYX_22051013_PIPE_PERF_EN
- Defined:
  - Adds outputs perf_mem_stall, perf_lu_bubble, perf_redirect (PERF_W each).
  - They increment on mem_stall cycles, case-4 cycles and case-3 cycles respectively.
  - They wrap on overflow and reset to 0.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- define.v gets: FSM state encodings (M_IDLE = 2'd0, M_WAIT = 2'd1, M_ERR = 2'd2), REG_AW width macro, MEM_TMO default.
- One sub-module, ysyx_22051013_hazard_det: combinational lu_hit from ID/EX fields, reusable by a later forwarding unit.
- FSM, priority logic and redirect latch stay in the top module.

Test Plan:
- ex_is_load = 1, ex_rd = 5, id_rs1 = 5 ren -> one cycle pc_stall = ifid_stall = idex_flush = 1; next cycle (load in LS) all 0. Repeat with rd = 0 -> no stall.
- ls_mem_req high, ack after 3 cycles -> FSM IDLE→WAIT; 3 cycles of pc/ifid/idex/exls stall + lswb_flush; ack cycle: stalls 0, FSM IDLE.
- ex_redirect pulse during the 2nd WAIT cycle -> redirect_pend = 1 until ack. On the ack cycle: ifid_flush = idex_flush = 1, then redirect_pend = 0.
- ex_redirect and lu_hit together, no mem stall -> ifid_flush = idex_flush = 1, pc_stall = 0, no latch.
- ls_mem_req held, no ack, MEM_TMO = 4 -> M_ERR after 4 WAIT cycles, mem_tmo_err = 1 sticky, stalls held. rst -> all 0.
- ex_mc_busy 5 cycles with if_fetch_busy -> pc/ifid/idex stall + exls_flush for 5 cycles. Then a fetch-busy cycle gives pc_stall + ifid_flush.
